sd_pic_saver: RTL and testbench
===============================

# sd_pic_saver

Screenshot writer for the SD/SDRAM/HDMI display path: on a save request it streams one full RGB565 frame from a show-ahead pixel FIFO into consecutive SD card sectors through the write port of `sd_ctrl_top`. It performs the write half of what the multi-picture loader does for reads, producing a valid BMP file at a fixed sector address. It sits in the `clk_50m` domain between an SDRAM read FIFO and the SD controller's `wr_start_en/wr_sec_addr/wr_data/wr_busy/wr_req` interface.

## Interface
- `H_PIX`, 1024: frame width in pixels.
- `V_PIX`, 768: frame height in pixels. `H_PIX*V_PIX` must be a multiple of 256.
- `BASE_SEC`, 32'd100000: first SD sector of the file.
- `clk`  in  1: system clock (50 MHz). One clock domain.
- `rst_n`  in  1: asynchronous, active-low reset.
- `save_start`  in  1: one-cycle save request.
- `pix_rd_data`  in  16: FIFO head word, show-ahead, valid when `pix_empty`=0.
- `pix_empty`  in  1: FIFO empty.
- `pix_rd_en`  out  1: FIFO pop, combinational.
- `wr_start_en`  out  1: sector write start pulse to SD controller.
- `wr_sec_addr`  out  32: sector address, stable from `wr_start_en` until `wr_busy` falls.
- `wr_data`  out  16: registered write word.
- `wr_busy`  in  1: SD controller write in progress.
- `wr_req`  in  1: SD controller requests next word, which it samples the following cycle.
- `save_busy`  out  1: high from accept to done.
- `save_done`  out  1: one-cycle pulse at end of file.
- `underrun`  out  1: sticky, set when `wr_req` finds the FIFO empty. Cleared on the next accepted `save_start`.

## Operation
- States: IDLE, START, WAIT_HI, WAIT_LO, DONE.
- IDLE:
  - `save_start`=1 → START. Clear the sector counter, word index and `underrun`.
  - `save_start` is ignored in every other state.
- START:
  - Drive `wr_start_en`=1 for exactly one cycle with `wr_sec_addr` = `BASE_SEC` + sector counter.
  - → WAIT_HI.
- WAIT_HI:
  - Wait for `wr_busy`=1, then → WAIT_LO.
  - There is no timeout.
- WAIT_LO, on each `wr_req`:
  - Increment the word index, 0..255.
  - In a pixel sector: `wr_data` <= `pix_rd_data` and `pix_rd_en`=1.
  - If `pix_empty`=1: `wr_data` <= 0, no pop, set `underrun`.
  - After the 256th word, further `wr_req` in the same sector drive 0 and do not pop.
- WAIT_LO, on `wr_busy` falling (sampled low):
  - Increment the sector counter and reset the word index.
  - Last sector written → DONE. Otherwise → START.
- DONE: `save_done`=1 for one cycle, → IDLE.
- Pixel sectors: `H_PIX*V_PIX/256` sectors, pixels taken in FIFO order. Image is top-down (negative height).
- Word packing: the SD controller sends `wr_data[15:8]` first, so word k = {byte 2k, byte 2k+1} of the file.

## Timing
- Reset values: all outputs 0, state IDLE, counters 0.
- `save_start` in cycle n → `wr_start_en` and `save_busy` high in cycle n+1.
- `wr_req` in cycle n → `wr_data` valid in cycle n+1. `pix_rd_en` is high in cycle n.
- `wr_busy` low sampled in cycle n:
  - Next sector: `wr_start_en` in cycle n+1.
  - Final sector: `save_done` in cycle n+1 and `save_busy` low in cycle n+2.
- `wr_req` together with `wr_busy` falling: the word is accepted first, then the sector ends.
- `rst_n` low mid-operation: immediate return to IDLE. No partial-sector completion. The FIFO is not popped during reset.
- `wr_sec_addr` holds its last value in IDLE.

## Configuration
- `SD_BMP_HDR_EN` defined:
  - A header sector is written at `BASE_SEC`; pixel sectors start at `BASE_SEC+1`.
  - Header = 66 bytes (33 words), little-endian fields, in this order:
    - "BM"; bfSize = 512+H*V*2; reserved 0; bfOffBits = 512.
    - biSize = 40; width `H_PIX`; height −`V_PIX`; planes 1; bpp 16; compression 3.
    - imagesize H*V*2; then four zero fields.
    - Masks F800, 07E0, 001F.
  - Words 33..255 of the header sector are 0. The header sector never pops the FIFO.
- Not defined: no header sector; raw pixel sectors start at `BASE_SEC`.

## Test plan
- Header: `SD_BMP_HDR_EN`, `H_PIX`=`V_PIX`=16, `BASE_SEC`=100 → two sectors at 100 and 101. Header word 0 = 16'h424D, word 5 = 16'h0002 (bfOffBits), word 33 = 0.
- Raw frame: no macro, 16×32, FIFO holds an incrementing pattern 0..511 → sectors 100 and 101 carry words 0..255 and 256..511 in order. Exactly 512 pops. `save_done` one cycle after the second `wr_busy` fall. `underrun`=0.
- Underrun: FIFO empty for `wr_req` #10 → that word is 0, no pop, `underrun`=1 and stays set until the next `save_start`.
- Request while busy: second `save_start` mid-file → ignored. Exactly one file is written, with the same sector count.
- Extra requests: 258 `wr_req` in one sector → words 256 and 257 are 0. The pop count stays 256.
- Reset mid-file: `rst_n` low during sector 1 → all outputs 0 the same cycle. A new `save_start` restarts at `BASE_SEC`.

Source files
------------

// File: rtl/sd_pic_saver.sv
// Streams one RGB565 frame from a show-ahead FIFO into consecutive SD sectors as a BMP file.
// Optional macro SD_BMP_HDR_EN prepends a 66-byte BMP header sector at BASE_SEC.
module sd_pic_saver #(
    parameter int          H_PIX    = 1024,
    parameter int          V_PIX    = 768,
    parameter logic [31:0] BASE_SEC = 32'd100000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        save_start_i,
    input  logic [15:0] pix_rd_data_i,
    input  logic        pix_empty_i,
    output logic        pix_rd_en_o,
    output logic        wr_start_en_o,
    output logic [31:0] wr_sec_addr_o,
    output logic [15:0] wr_data_o,
    input  logic        wr_busy_i,
    input  logic        wr_req_i,
    output logic        save_busy_o,
    output logic        save_done_o,
    output logic        underrun_o
);
    // state     | meaning
    // S_IDLE    | waiting for save_start
    // S_START   | wr_start_en pulse for the current sector
    // S_WAIT_HI | waiting for the SD controller to go busy
    // S_WAIT_LO | serving wr_req until wr_busy falls
    // S_DONE    | save_done pulse, back to idle

    localparam int N_PIX_SEC = (H_PIX * V_PIX) / 256;
`ifdef SD_BMP_HDR_EN
    localparam int HDR_SEC = 1;
`else
    localparam int HDR_SEC = 0;
`endif
    localparam int N_SEC = N_PIX_SEC + HDR_SEC;
    localparam int SEC_W = (N_SEC > 1) ? $clog2(N_SEC) : 1;
    localparam logic [SEC_W-1:0] LAST_SEC = SEC_W'(N_SEC - 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_WAIT_HI, S_WAIT_LO, S_DONE} state_t;

    state_t           state_q;
    logic [SEC_W-1:0] sec_q;
    logic [8:0]       word_q;
    logic             wr_start_en_q;
    logic [31:0]      wr_sec_addr_q;
    logic [15:0]      wr_data_q;
    logic             save_busy_q;
    logic             save_done_q;
    logic             underrun_q;
    logic [15:0]      word_d;
    logic             pix_sec;
    logic             pix_slot;

`ifdef SD_BMP_HDR_EN
    localparam logic [31:0] FILE_SZ = 32'(512 + H_PIX * V_PIX * 2);
    localparam logic [31:0] IMG_SZ  = 32'(H_PIX * V_PIX * 2);
    localparam logic [31:0] WIDTH   = 32'(H_PIX);
    localparam logic [31:0] HEIGHT  = 32'(0 - V_PIX);

    // File bytes go out high byte first, so each little-endian half is byte-swapped.
    function automatic logic [15:0] sw(input logic [15:0] x);
        return {x[7:0], x[15:8]};
    endfunction

    logic [15:0] hdr_word;

    always_comb begin
        hdr_word = '0;
        case (word_q)
            9'd0:  hdr_word = 16'h424D;
            9'd1:  hdr_word = sw(FILE_SZ[15:0]);
            9'd2:  hdr_word = sw(FILE_SZ[31:16]);
            9'd5:  hdr_word = sw(16'd512);
            9'd7:  hdr_word = sw(16'd40);
            9'd9:  hdr_word = sw(WIDTH[15:0]);
            9'd10: hdr_word = sw(WIDTH[31:16]);
            9'd11: hdr_word = sw(HEIGHT[15:0]);
            9'd12: hdr_word = sw(HEIGHT[31:16]);
            9'd13: hdr_word = sw(16'd1);
            9'd14: hdr_word = sw(16'd16);
            9'd15: hdr_word = sw(16'd3);
            9'd17: hdr_word = sw(IMG_SZ[15:0]);
            9'd18: hdr_word = sw(IMG_SZ[31:16]);
            9'd27: hdr_word = sw(16'hF800);
            9'd29: hdr_word = sw(16'h07E0);
            9'd31: hdr_word = sw(16'h001F);
            default: hdr_word = '0;
        endcase
    end

    assign pix_sec = (sec_q != '0);
`else
    assign pix_sec = 1'b1;
`endif

    // word_q saturates at 256; bit 8 marks requests past the end of the sector.
    assign pix_slot    = (state_q == S_WAIT_LO) && wr_req_i && !word_q[8] && pix_sec;
    assign pix_rd_en_o = pix_slot && !pix_empty_i;

    always_comb begin
        word_d = '0;
        if (!word_q[8]) begin
            if (pix_sec) begin
                if (!pix_empty_i) word_d = pix_rd_data_i;
            end
`ifdef SD_BMP_HDR_EN
            else begin
                word_d = hdr_word;
            end
`endif
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= S_IDLE;
            sec_q         <= '0;
            word_q        <= '0;
            wr_start_en_q <= 1'b0;
            wr_sec_addr_q <= '0;
            wr_data_q     <= '0;
            save_busy_q   <= 1'b0;
            save_done_q   <= 1'b0;
            underrun_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (save_start_i) begin
                        state_q       <= S_START;
                        sec_q         <= '0;
                        word_q        <= '0;
                        underrun_q    <= 1'b0;
                        wr_start_en_q <= 1'b1;
                        wr_sec_addr_q <= BASE_SEC;
                        save_busy_q   <= 1'b1;
                    end
                end
                S_START: begin
                    wr_start_en_q <= 1'b0;
                    state_q       <= S_WAIT_HI;
                end
                S_WAIT_HI: begin
                    if (wr_busy_i) state_q <= S_WAIT_LO;
                end
                S_WAIT_LO: begin
                    if (wr_req_i) begin
                        wr_data_q <= word_d;
                        if (!word_q[8]) word_q <= word_q + 9'd1;
                        if (pix_slot && pix_empty_i) underrun_q <= 1'b1;
                    end
                    // Sector end overrides the index update so a same-cycle word still lands first.
                    if (!wr_busy_i) begin
                        word_q <= '0;
                        if (sec_q == LAST_SEC) begin
                            state_q     <= S_DONE;
                            save_done_q <= 1'b1;
                        end else begin
                            sec_q         <= sec_q + 1'b1;
                            state_q       <= S_START;
                            wr_start_en_q <= 1'b1;
                            wr_sec_addr_q <= BASE_SEC + 32'(sec_q) + 32'd1;
                        end
                    end
                end
                S_DONE: begin
                    save_done_q <= 1'b0;
                    save_busy_q <= 1'b0;
                    state_q     <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign wr_start_en_o = wr_start_en_q;
    assign wr_sec_addr_o = wr_sec_addr_q;
    assign wr_data_o     = wr_data_q;
    assign save_busy_o   = save_busy_q;
    assign save_done_o   = save_done_q;
    assign underrun_o    = underrun_q;

endmodule

// File: tb/tb_sd_pic_saver.sv
// Scoreboard bench for sd_pic_saver: 16x32 frame at sector 100, SD controller and FIFO modelled here.
module tb_sd_pic_saver;
    localparam int          H    = 16;
    localparam int          V    = 32;
    localparam logic [31:0] BASE = 32'd100;
    localparam int          NPIX = H * V;
`ifdef SD_BMP_HDR_EN
    localparam int HDR_SEC = 1;
`else
    localparam int HDR_SEC = 0;
`endif
    localparam int NSEC = NPIX / 256 + HDR_SEC;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        save_start = 1'b0;
    logic [15:0] pix_rd_data = 16'hDEAD;
    logic        pix_empty = 1'b1;
    logic        pix_rd_en;
    logic        wr_start_en;
    logic [31:0] wr_sec_addr;
    logic [15:0] wr_data;
    logic        wr_busy = 1'b0;
    logic        wr_req = 1'b0;
    logic        save_busy;
    logic        save_done;
    logic        underrun;

    sd_pic_saver #(.H_PIX(H), .V_PIX(V), .BASE_SEC(BASE)) dut (
        .clk_i(clk), .rst_ni(rst_n), .save_start_i(save_start),
        .pix_rd_data_i(pix_rd_data), .pix_empty_i(pix_empty), .pix_rd_en_o(pix_rd_en),
        .wr_start_en_o(wr_start_en), .wr_sec_addr_o(wr_sec_addr), .wr_data_o(wr_data),
        .wr_busy_i(wr_busy), .wr_req_i(wr_req), .save_busy_o(save_busy),
        .save_done_o(save_done), .underrun_o(underrun)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    logic [15:0] exp_w[$];
    logic [31:0] exp_a[$];
    logic [15:0] fifo[$];
    bit          force_empty = 1'b0;
    bit          rd_en_s = 1'b0;
    bit          req_prev = 1'b0;
    int          pops = 0;
    int          exp_next = 0;
    logic [15:0] pat_base = '0;
    logic [7:0]  hb[0:65];
    logic [15:0] hdr_w[0:255];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic void upd_fifo();
        pix_empty   = force_empty || (fifo.size() == 0);
        pix_rd_data = (fifo.size() > 0) ? fifo[0] : 16'hDEAD;
    endfunction

    function automatic void put32(input int off, input logic [31:0] v);
        hb[off] = v[7:0]; hb[off+1] = v[15:8]; hb[off+2] = v[23:16]; hb[off+3] = v[31:24];
    endfunction

    function automatic void build_hdr();
        for (int i = 0; i < 66; i++) hb[i] = 8'h00;
        hb[0] = 8'h42; hb[1] = 8'h4D;
        put32(2, 32'(512 + NPIX * 2));
        put32(10, 32'd512);
        put32(14, 32'd40);
        put32(18, 32'(H));
        put32(22, 32'(0 - V));
        hb[26] = 8'd1;
        hb[28] = 8'd16;
        put32(30, 32'd3);
        put32(34, 32'(NPIX * 2));
        put32(54, 32'h0000F800);
        put32(58, 32'h000007E0);
        put32(62, 32'h0000001F);
        for (int k = 0; k < 256; k++) hdr_w[k] = (k < 33) ? {hb[2*k], hb[2*k+1]} : 16'h0000;
    endfunction

    function automatic void load_fifo(input logic [15:0] base);
        fifo.delete();
        for (int i = 0; i < NPIX; i++) fifo.push_back(base + 16'(i));
        pat_base = base;
        exp_next = 0;
        pops     = 0;
        upd_fifo();
    endfunction

    always @(negedge clk) rd_en_s = pix_rd_en;

    always @(posedge clk) begin
        #1;
        if (rd_en_s) begin
            if (fifo.size() > 0) void'(fifo.pop_front());
            pops++;
            rd_en_s = 1'b0;
            upd_fifo();
        end
    end

    // Monitor: a word is due the cycle after each wr_req; a sector address on each wr_start_en.
    always @(negedge clk) begin
        if (rst_n && req_prev) begin
            if (exp_w.size() == 0) chk("wr_data_unexpected", {16'h0, wr_data}, 32'hFFFFFFFF);
            else chk("wr_data", {16'h0, wr_data}, {16'h0, exp_w.pop_front()});
        end
        req_prev = rst_n && wr_req;
        if (rst_n && wr_start_en) begin
            if (exp_a.size() == 0) chk("wr_start_unexpected", wr_sec_addr, 32'hFFFFFFFF);
            else chk("wr_sec_addr", wr_sec_addr, exp_a.pop_front());
        end
    end

    // Entered at a negedge while wr_start_en is high; returns at the negedge after wr_busy was seen low.
    task automatic do_sector(input bit hdr, input int nreq, input bit together, input int ur_at,
                             input bit mid_start, input int abort_at);
        logic [15:0] e;
        @(posedge clk); #1 wr_busy = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        for (int k = 0; k < nreq; k++) begin
            if (k == abort_at) return;
            if (k >= 256) e = 16'h0000;
            else if (hdr) e = hdr_w[k];
            else if (k == ur_at) e = 16'h0000;
            else begin
                e = pat_base + 16'(exp_next);
                exp_next++;
            end
            exp_w.push_back(e);
            force_empty = (k == ur_at);
            upd_fifo();
            wr_req = 1'b1;
            if (mid_start && k == 3) save_start = 1'b1;
            if (together && k == nreq - 1) wr_busy = 1'b0;
            @(posedge clk); #1;
            wr_req = 1'b0;
            save_start = 1'b0;
            force_empty = 1'b0;
            upd_fifo();
            if (!(together && k == nreq - 1)) begin
                @(posedge clk); #1;
            end
        end
        if (!together) begin
            wr_busy = 1'b0;
            @(posedge clk); #1;
        end
        @(negedge clk);
    endtask

    task automatic start_file(input int nsec_exp);
        for (int s = 0; s < nsec_exp; s++) exp_a.push_back(BASE + 32'(s));
        save_start = 1'b1;
        @(posedge clk); #1 save_start = 1'b0;
        @(negedge clk);
        chk("start_latency", {31'b0, wr_start_en}, 32'd1);
        chk("busy_on_start", {31'b0, save_busy}, 32'd1);
        chk("underrun_cleared", {31'b0, underrun}, 32'd0);
    endtask

    task automatic run_file(input int nreq, input bit together, input int ur_at, input bit mid_start);
        start_file(NSEC);
        for (int s = 0; s < NSEC; s++) begin
            do_sector(HDR_SEC == 1 && s == 0, nreq, together && s == NSEC - 1,
                      (s == HDR_SEC) ? ur_at : -1, mid_start && s == 0, -1);
            if (s < NSEC - 1) begin
                chk("next_sector_start", {31'b0, wr_start_en}, 32'd1);
            end else begin
                chk("save_done_pulse", {31'b0, save_done}, 32'd1);
                chk("busy_in_done", {31'b0, save_busy}, 32'd1);
                @(negedge clk);
                chk("busy_after_done", {31'b0, save_busy}, 32'd0);
                chk("done_one_cycle", {31'b0, save_done}, 32'd0);
            end
        end
        @(posedge clk); #1;
    endtask

    initial begin
        build_hdr();
        upd_fifo();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_wr_start_en", {31'b0, wr_start_en}, 32'd0);
        chk("rst_wr_sec_addr", wr_sec_addr, 32'd0);
        chk("rst_wr_data", {16'h0, wr_data}, 32'd0);
        chk("rst_save_busy", {31'b0, save_busy}, 32'd0);
        chk("rst_save_done", {31'b0, save_done}, 32'd0);
        chk("rst_underrun", {31'b0, underrun}, 32'd0);
        chk("rst_pix_rd_en", {31'b0, pix_rd_en}, 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (2) @(posedge clk); #1;

        // Raw/normal frame; last word arrives together with the final wr_busy fall.
        load_fifo(16'h0000);
        run_file(256, 1'b1, -1, 1'b0);
        chk("pops_full_frame", 32'(pops), 32'(NPIX));
        chk("underrun_clean", {31'b0, underrun}, 32'd0);
        chk("fifo_drained", 32'(fifo.size()), 32'd0);
        repeat (10) @(posedge clk); #1;
        chk("addr_holds_idle", wr_sec_addr, BASE + 32'(NSEC - 1));

        // Underrun on request #10 plus an ignored save_start mid-file.
        load_fifo(16'h1000);
        run_file(256, 1'b0, 9, 1'b1);
        chk("underrun_set", {31'b0, underrun}, 32'd1);
        chk("pops_underrun", 32'(pops), 32'(NPIX - 1));
        repeat (10) @(posedge clk); #1;
        chk("underrun_sticky", {31'b0, underrun}, 32'd1);
        chk("exp_addr_empty_after_busy_start", 32'(exp_a.size()), 32'd0);
        fifo.delete(); upd_fifo();

        // 258 requests per sector: two trailing zero words, no extra pops.
        load_fifo(16'h2000);
        run_file(258, 1'b0, -1, 1'b0);
        chk("pops_extra_req", 32'(pops), 32'(NPIX));
        chk("underrun_extra", {31'b0, underrun}, 32'd0);

        // Reset in the middle of sector 1.
        load_fifo(16'h3000);
        start_file(2);
        do_sector(HDR_SEC == 1, 256, 1'b0, -1, 1'b0, -1);
        chk("next_sector_start", {31'b0, wr_start_en}, 32'd1);
        do_sector(1'b0, 256, 1'b0, -1, 1'b0, 5);
        wr_req = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("midrst_wr_start_en", {31'b0, wr_start_en}, 32'd0);
        chk("midrst_wr_sec_addr", wr_sec_addr, 32'd0);
        chk("midrst_wr_data", {16'h0, wr_data}, 32'd0);
        chk("midrst_save_busy", {31'b0, save_busy}, 32'd0);
        chk("midrst_pix_rd_en", {31'b0, pix_rd_en}, 32'd0);
        begin
            int p0;
            p0 = pops;
            repeat (3) @(posedge clk); #1;
            wr_req = 1'b0;
            wr_busy = 1'b0;
            chk("midrst_no_pop", 32'(pops), 32'(p0));
        end
        exp_w.delete();
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (2) @(posedge clk); #1;

        load_fifo(16'h4000);
        run_file(256, 1'b0, -1, 1'b0);
        chk("pops_after_reset", 32'(pops), 32'(NPIX));

        chk("exp_words_left", 32'(exp_w.size()), 32'd0);
        chk("exp_addrs_left", 32'(exp_a.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
        $fatal(1);
    end

endmodule
